// File: rtl/divider_4bit_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the divide-by-zero quotient fill pattern.
package divider_4bit_seq_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Sliced to the instance width; a divide by zero reports an all-ones quotient.
   localparam logic [63:0] DBZ_QUOTIENT_FILL = '1;

endpackage

// File: rtl/divider_4bit_seq_subtractor_nbit.sv
// Combinational ripple-borrow subtractor (a - b), the mirror of the adder cell.
module subtractor_nbit
   import divider_4bit_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH + 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   logic [WIDTH:0] borrow;

   assign borrow[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         assign diff[gi]       = a[gi] ^ b[gi] ^ borrow[gi];
         assign borrow[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow[gi]);
      end
   endgenerate

   assign borrow_out = borrow[WIDTH];

endmodule

// File: rtl/divider_4bit_seq.sv
// Iterative restoring divider, one quotient bit per clock, MSB first.
// Define DIVIDER_SIGNED_EN for two's-complement operands (default: unsigned).
module divider_4bit_seq
   import divider_4bit_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] DBZ_QUOTIENT = DBZ_QUOTIENT_FILL[WIDTH-1:0];

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [WIDTH-1:0] part_reg, part_next;
   logic [WIDTH-1:0] dvd_reg, dvd_next;
   logic [WIDTH-1:0] dvs_reg, dvs_next;
   logic [WIDTH-2:0] qacc_reg, qacc_next;
   logic [WIDTH-1:0] quotient_reg, quotient_next;
   logic [WIDTH-1:0] remainder_reg, remainder_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic             dbz_reg, dbz_next;
   logic             pend_reg, pend_next;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             borrow;
   logic [WIDTH-1:0] new_part;
   logic [WIDTH-1:0] new_q;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] q_final;
   logic [WIDTH-1:0] r_final;
   logic             unused_trial_msb;

   assign shifted  = {part_reg, dvd_reg[WIDTH-1]};
   assign new_part = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign new_q    = {qacc_reg, ~borrow};
   // A successful trial always leaves a result below the divisor, so the MSB is zero.
   assign unused_trial_msb = trial[WIDTH];

   subtractor_nbit #(
      .WIDTH(WIDTH + 1)
   ) u_sub (
      .a         (shifted),
      .b         ({1'b0, dvs_reg}),
      .diff      (trial),
      .borrow_out(borrow)
   );

`ifdef DIVIDER_SIGNED_EN
   logic neg_q_reg, neg_q_next;
   logic neg_r_reg, neg_r_next;

   assign dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
   assign dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
   assign q_final = neg_q_reg ? (~new_q + 1'b1)    : new_q;
   assign r_final = neg_r_reg ? (~new_part + 1'b1) : new_part;
`else
   assign dvd_mag = dividend;
   assign dvs_mag = divisor;
   assign q_final = new_q;
   assign r_final = new_part;
`endif

   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      part_next      = part_reg;
      dvd_next       = dvd_reg;
      dvs_next       = dvs_reg;
      qacc_next      = qacc_reg;
      quotient_next  = quotient_reg;
      remainder_next = remainder_reg;
      busy_next      = busy_reg;
      done_next      = 1'b0;
      dbz_next       = dbz_reg;
      pend_next      = pend_reg;
`ifdef DIVIDER_SIGNED_EN
      neg_q_next     = neg_q_reg;
      neg_r_next     = neg_r_reg;
`endif

      case (state_reg)
         RUN: begin
            part_next  = new_part;
            dvd_next   = {dvd_reg[WIDTH-2:0], 1'b0};
            qacc_next  = new_q[WIDTH-2:0];
            count_next = count_reg + 1'b1;
            if (count_reg == LAST_COUNT) begin
               quotient_next  = q_final;
               remainder_next = r_final;
               done_next      = 1'b1;
               busy_next      = 1'b0;
               count_next     = '0;
               state_next     = DONE;
            end
         end
         default: begin
            // A zero divisor spends one cycle in DONE before publishing, holding off new starts.
            if (pend_reg) begin
               quotient_next  = DBZ_QUOTIENT;
               remainder_next = dvd_reg;
               dbz_next       = 1'b1;
               done_next      = 1'b1;
               pend_next      = 1'b0;
               state_next     = DONE;
            end else if (start) begin
               dbz_next   = 1'b0;
               dvs_next   = dvs_mag;
               part_next  = '0;
               qacc_next  = '0;
               count_next = '0;
`ifdef DIVIDER_SIGNED_EN
               neg_q_next = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               neg_r_next = dividend[WIDTH-1];
`endif
               if (divisor != '0) begin
                  dvd_next   = dvd_mag;
                  busy_next  = 1'b1;
                  state_next = RUN;
               end else begin
                  dvd_next   = dividend;
                  pend_next  = 1'b1;
                  state_next = DONE;
               end
            end else begin
               state_next = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         part_reg      <= '0;
         dvd_reg       <= '0;
         dvs_reg       <= '0;
         qacc_reg      <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         dbz_reg       <= 1'b0;
         pend_reg      <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         neg_q_reg     <= 1'b0;
         neg_r_reg     <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         part_reg      <= part_next;
         dvd_reg       <= dvd_next;
         dvs_reg       <= dvs_next;
         qacc_reg      <= qacc_next;
         quotient_reg  <= quotient_next;
         remainder_reg <= remainder_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         dbz_reg       <= dbz_next;
         pend_reg      <= pend_next;
`ifdef DIVIDER_SIGNED_EN
         neg_q_reg     <= neg_q_next;
         neg_r_reg     <= neg_r_next;
`endif
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign quotient    = quotient_reg;
   assign remainder   = remainder_reg;
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_divider_4bit_seq.sv
// Scoreboard bench for divider_4bit_seq; expected results queued at start, checked on done.
module tb_divider_4bit_seq;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           e0;
      int           lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   done_count = 0;
   int   issued = 0;

   divider_4bit_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      logic [31:0] t;
      e.a = a;
      e.b = b;
      e.e0 = 0;
      if (b == 0) begin
         e.q   = '1;
         e.r   = a;
         e.dbz = 1'b1;
         e.lat = 1;
      end else begin
`ifdef DIVIDER_SIGNED_EN
         logic signed [W-1:0] sa;
         logic signed [W-1:0] sbv;
         int ia;
         int ib;
         sa  = a;
         sbv = b;
         ia  = sa;
         ib  = sbv;
         t   = ia / ib;
         e.q = t[W-1:0];
         t   = ia % ib;
         e.r = t[W-1:0];
`else
         t   = 32'(a) / 32'(b);
         e.q = t[W-1:0];
         t   = 32'(a) % 32'(b);
         e.r = t[W-1:0];
`endif
         e.dbz = 1'b0;
         e.lat = W;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (done) begin
         done_count++;
         if (sb.size() == 0) begin
            check_value("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check_value("quotient", quotient, mon_e.q);
            check_value("remainder", remainder, mon_e.r);
            check_value("div_by_zero", div_by_zero, mon_e.dbz);
            check_value("latency", cyc - mon_e.e0, mon_e.lat);
            $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0d at cycle %0d",
                     mon_e.a, mon_e.b, quotient, remainder, div_by_zero, cyc);
         end
      end
   end

   // Drives start for one edge from posedge+1; returns just after the accepting edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_result);
      exp_t e;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      if (expect_result) begin
         e    = model(a, b);
         e.e0 = cyc + 1;
         sb.push_back(e);
         issued++;
      end
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = ~a;
      divisor  = ~b;
      check_value("busy_after_start", busy, 32'(b != 0));
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!seen) check_value("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b);
      issue(a, b, 1'b1);
      wait_done(20);
      @(posedge clk);
      #1;
      check_value("done_pulse_width", done, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_busy"}, busy, 32'd0);
      check_value({tag, "_done"}, done, 32'd0);
      check_value({tag, "_quotient"}, quotient, 32'd0);
      check_value({tag, "_remainder"}, remainder, 32'd0);
      check_value({tag, "_dbz"}, div_by_zero, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=%0d expected=0", cyc);
      $fatal(1, "simulation time limit");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_one(4'd13, 4'd3);
      run_one(4'd15, 4'd1);
      run_one(4'd2, 4'd7);
      run_one(4'd0, 4'd5);

      // Second start lands in the DONE cycle of the first.
      issue(4'd9, 4'd4, 1'b1);
      wait_done(20);
      issue(4'd11, 4'd2, 1'b1);
      wait_done(20);
      @(posedge clk);
      #1;
      check_value("b2b_done_drop", done, 32'd0);

      run_one(4'd9, 4'd0);
      run_one(4'd8, 4'd2);

      // Start while busy must be ignored.
      issue(4'd12, 4'd5, 1'b1);
      dividend = 4'd1;
      divisor  = 4'd1;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(20);
      repeat (6) @(posedge clk);
      #1;

      // Reset sampled on E0+2 aborts the division.
      issue(4'd14, 4'd3, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_outputs("abort");
      repeat (8) @(posedge clk);
      #1;
      check_reset_outputs("after_abort");
      run_one(4'd6, 4'd3);

`ifdef DIVIDER_SIGNED_EN
      run_one(4'b1001, 4'd2);
      run_one(4'd7, 4'b1110);
      run_one(4'b1000, 4'b1111);
`endif

      for (int i = 0; i < 20; i++) begin
         run_one(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      repeat (4) @(posedge clk);
      #1;
      check_value("scoreboard_empty", sb.size(), 32'd0);
      check_value("done_count", done_count, issued);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
